ring_freq_counter: RTL
======================

Name: ring_freq_counter

Overview:
- Downstream measurement stage for the on-chip inverter ring oscillator.
- Samples the free-running ring output in the system clock domain and counts its rising edges over a fixed gate window of 2^GATE_LOG2 clk cycles.
- Presents each result on a valid/ready output port, so the top level can drive it onto uo_out or hand it to a serialiser.
- Supports single-shot and continuous measurement.

Parameters:
- GATE_LOG2, 10, gate window length is 2^GATE_LOG2 clk cycles (legal range 2..20).
- CNT_W, 16, width of the edge counter and of the result.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- ring_in  input  1  raw ring oscillator output, asynchronous to clk.
- start  input  1  level; sampled in IDLE, starts one measurement.
- continuous  input  1  level; when high, a new window starts automatically after each result is accepted, and IDLE auto-starts.
- count  output  CNT_W  measured rising-edge count for the last window.
- count_valid  output  1  count holds an unconsumed result.
- count_ready  input  1  consumer accepts count when count_valid && count_ready.
- overflow  output  1  the last result saturated; qualified by count_valid.
- busy  output  1  high in GATE and HOLD.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All flops, including the synchronizer, reset on a clk edge with rst=1.
- Reset values: count=0, count_valid=0, overflow=0, busy=0, state=IDLE, internal counters=0, sync/prev flops=0.
- Front end:
  - 2-flop synchronizer on ring_in, then a prev register.
  - rise = sync2 & ~prev.
  - Requires f_ring < f_clk/2; faster input aliases and is not detected.
- States and transitions:
  - IDLE: if start || continuous, go to GATE next cycle, with gate_cnt=0 and edge_cnt=0.
  - GATE:
    - Every cycle gate_cnt += 1.
    - If rise, edge_cnt += 1, saturating at 2^CNT_W-1; a rise while edge_cnt is at max sets ovf_int.
    - The cycle with gate_cnt == 2^GATE_LOG2-1 is the last window cycle, and a rise in that cycle is counted.
    - On that edge: count <= final edge_cnt (including that cycle's rise, saturated), overflow <= ovf_int (updated likewise), count_valid <= 1, go to HOLD.
    - The window is exactly 2^GATE_LOG2 cycles.
  - HOLD:
    - count, overflow and count_valid stay stable until the handshake.
    - On count_valid && count_ready: count_valid <= 0. If continuous, go to GATE with counters cleared; otherwise go to IDLE.
    - Dead time between back-to-back windows is exactly 1 cycle (the HOLD accept cycle).
- Rules:
  - start while in GATE or HOLD is ignored; there is no queueing.
  - continuous deasserted mid-window: the current window completes, then IDLE after accept.
  - count_ready while count_valid=0 has no effect.
  - rst mid-window aborts the window and discards the partial count; a result not yet consumed is dropped.
  - count keeps its last value after accept; it is only overwritten at the next window end.
  - Edge counter and gate counter are independent. The gate counter is GATE_LOG2 bits wide and wraps only at the state transition.
- Latency: from the cycle start is sampled high in IDLE to count_valid high is 2^GATE_LOG2+1 cycles.

Test Plan:
- Basic count: GATE_LOG2=6, CNT_W=16; ring_in square wave with period 8 clk; start pulsed 1 cycle -> count_valid rises 65 cycles after start, count=8, overflow=0, busy high throughout.
- Static input: ring_in held 0, then held 1, one window each -> count=0 both times, overflow=0.
- Saturation: CNT_W=4, GATE_LOG2=6, ring_in period 2 -> count=15, overflow=1.
- Backpressure: count_ready held low for 50 cycles after count_valid -> count, overflow and count_valid unchanged, no new window (busy stays high in HOLD), start pulses ignored; ready high for 1 cycle -> count_valid low next cycle, state IDLE.
- Continuous mode: continuous=1, ring_in period 16, GATE_LOG2=8, count_ready=1 -> results of 16 each window, count_valid pulses every 257 cycles; deassert continuous mid-window -> exactly one more result, then IDLE.
- Reset mid-window: rst for 1 cycle at gate cycle 30 -> all outputs at reset values next cycle; no count_valid until a fresh start, after which the result equals a full clean window count.

Source files
------------

// File: rtl/ring_freq_counter_if.sv
// ---------------------------------------------------------------------------
// ring_freq_counter_if
// Result port of the ring oscillator frequency counter: a measured count with
// its overflow flag, moved with a valid/ready handshake.
//   count       : measured rising-edge count of the last gate window
//   count_valid : count holds a result the consumer has not yet taken
//   count_ready : consumer takes count when count_valid && count_ready
//   overflow    : the result saturated; only meaningful with count_valid
// master = the counter (producer), slave = the consumer.
// ---------------------------------------------------------------------------
interface ring_freq_counter_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             count_ready;
    logic             overflow;

    modport master (
        output count,
        output count_valid,
        output overflow,
        input  count_ready
    );

    modport slave (
        input  count,
        input  count_valid,
        input  overflow,
        output count_ready
    );
endinterface

// File: rtl/ring_freq_counter.sv
// ---------------------------------------------------------------------------
// ring_freq_counter
// Counts rising edges of the free-running ring oscillator over a gate window
// of 2^GATE_LOG2 clk cycles and offers each result on a valid/ready port.
// Single-shot (start) and continuous (continuous) measurement are supported.
//   clk          : system clock, the only clock in the block
//   rst          : synchronous active-high reset
//   ring_in_i    : raw ring output, asynchronous to clk (must be < f_clk/2)
//   start_i      : level, starts one measurement when sampled in IDLE
//   continuous_i : level, auto-start from IDLE and re-arm after each accept
//   busy_o       : high while a window runs or a result waits (GATE/HOLD)
//   res          : result port (count, count_valid, count_ready, overflow)
// ---------------------------------------------------------------------------
module ring_freq_counter #(
    parameter int GATE_LOG2 = 10,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ring_in_i,
    input  logic                start_i,
    input  logic                continuous_i,
    output logic                busy_o,
    ring_freq_counter_if.master res
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic [GATE_LOG2-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_q;

    logic                   rise_s;
    logic                   edge_max_s;
    logic                   last_s;
    logic [CNT_W-1:0]       edge_next_s;
    logic                   ovf_next_s;

    assign rise_s     = sync2_q & ~prev_q;
    assign edge_max_s = &edge_cnt_q;
    // gate_cnt all-ones marks the final cycle of the window
    assign last_s     = &gate_cnt_q;

    // Saturating edge count and sticky overflow including this cycle's rise
    always_comb begin
        edge_next_s = edge_cnt_q;
        ovf_next_s  = ovf_q;
        if (rise_s && !edge_max_s) begin
            edge_next_s = edge_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (rise_s) begin
            ovf_next_s = 1'b1;
        end else begin
            edge_next_s = edge_cnt_q;
        end
    end

    // Next-state and result logic
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i || continuous_i) begin
                    state_d    = ST_GATE;
                    gate_cnt_d = {GATE_LOG2{1'b0}};
                    edge_cnt_d = {CNT_W{1'b0}};
                    ovf_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE: begin
                // Wraps to zero on the last cycle, so the next window starts clean
                gate_cnt_d = gate_cnt_q + {{(GATE_LOG2-1){1'b0}}, 1'b1};
                edge_cnt_d = edge_next_s;
                ovf_d      = ovf_next_s;
                if (last_s) begin
                    count_d    = edge_next_s;
                    overflow_d = ovf_next_s;
                    valid_d    = 1'b1;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_GATE;
                end
            end
            ST_HOLD: begin
                if (valid_q && res.count_ready) begin
                    valid_d = 1'b0;
                    if (continuous_i) begin
                        state_d    = ST_GATE;
                        gate_cnt_d = {GATE_LOG2{1'b0}};
                        edge_cnt_d = {CNT_W{1'b0}};
                        ovf_d      = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            gate_cnt_q <= {GATE_LOG2{1'b0}};
            edge_cnt_q <= {CNT_W{1'b0}};
            ovf_q      <= 1'b0;
            count_q    <= {CNT_W{1'b0}};
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= ring_in_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign res.count       = count_q;
    assign res.count_valid = valid_q;
    assign res.overflow    = overflow_q;
    assign busy_o          = busy_q;

endmodule
